// File: rtl/decoder_3to8_seq.sv
// decoder_3to8_seq: flow-controlled 3-to-8 decoder with a small input FIFO.
// Each buffered code is replayed as a HOLD-cycle one-hot pulse followed by GAP all-zero cycles.
module decoder_3to8_seq #(
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic d4,
    output logic d5,
    output logic d6,
    output logic d7,
    output logic out_valid,
    output logic busy
);
    localparam int         AW        = $clog2(DEPTH);
    localparam bit         GAP_EN    = (GAP > 0);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = GAP_EN ? 8'(GAP - 1) : 8'd0;
    localparam logic [AW:0] PTR_INC  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic [2:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_d;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  dec_q;
    logic        out_valid_q;
    logic        busy_q;

    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic        nempty_d_s;
    logic [2:0]  head_s;

    function automatic logic [7:0] onehot(input logic [2:0] code);
        onehot = 8'd1 << code;
    endfunction

    // FIFO status, handshake and pop decision; the pop is taken only at the end of a window or from IDLE
    always_comb begin
        full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_s  = (wr_ptr_q == rd_ptr_q);
        in_ready = !full_s && rst_n;
        push_s   = in_valid && in_ready;
        head_s   = mem_q[rd_ptr_q[AW-1:0]];
        pop_s    = 1'b0;
        case (state_q)
            ST_IDLE:  pop_s = !empty_s;
            ST_DRIVE: pop_s = (cnt_q == 8'd0) && !GAP_EN && !empty_s;
            ST_GAP:   pop_s = (cnt_q == 8'd0) && !empty_s;
            default:  pop_s = 1'b0;
        endcase
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        nempty_d_s = (wr_ptr_d != rd_ptr_d);
    end

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {a, b, c};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Replay FSM with registered one-hot, valid and busy outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            dec_q       <= 8'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_q     <= ST_DRIVE;
                        cnt_q       <= HOLD_LOAD;
                        dec_q       <= onehot(head_s);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        dec_q       <= 8'd0;
                        out_valid_q <= 1'b0;
                        busy_q      <= nempty_d_s;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == 8'd0) begin
                        if (GAP_EN) begin
                            state_q     <= ST_GAP;
                            cnt_q       <= GAP_LOAD;
                            dec_q       <= 8'd0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end else if (pop_s) begin
                            // back-to-back windows stay in DRIVE so equal codes form one pulse
                            cnt_q       <= HOLD_LOAD;
                            dec_q       <= onehot(head_s);
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            dec_q       <= 8'd0;
                            out_valid_q <= 1'b0;
                            busy_q      <= nempty_d_s;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 8'd0) begin
                        if (pop_s) begin
                            state_q     <= ST_DRIVE;
                            cnt_q       <= HOLD_LOAD;
                            dec_q       <= onehot(head_s);
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            busy_q      <= nempty_d_s;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= 8'd0;
                    dec_q       <= 8'd0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign {d7, d6, d5, d4, d3, d2, d1, d0} = dec_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Bench for decoder_3to8_seq: three parameterisations share one stimulus stream, each checked
// every cycle against a schedule-queue model, plus literal expectations for the directed cases.
module tb_decoder_3to8_seq;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] code_s;

    wire  [2:0] rdy_w;
    wire  [2:0] ov_w;
    wire  [2:0] busy_w;
    wire  [7:0] d_w [3];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inst0: HOLD=4 GAP=1 DEPTH=4, inst1: HOLD=4 GAP=0 DEPTH=4, inst2: HOLD=1 GAP=0 DEPTH=2
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int H = (g == 2) ? 1 : 4;
        localparam int G = (g == 0) ? 1 : 0;
        localparam int D = (g == 2) ? 2 : 4;

        decoder_3to8_seq #(.HOLD(H), .GAP(G), .DEPTH(D)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[g]),
            .a(code_s[2]), .b(code_s[1]), .c(code_s[0]),
            .d0(d_w[g][0]), .d1(d_w[g][1]), .d2(d_w[g][2]), .d3(d_w[g][3]),
            .d4(d_w[g][4]), .d5(d_w[g][5]), .d6(d_w[g][6]), .d7(d_w[g][7]),
            .out_valid(ov_w[g]), .busy(busy_w[g])
        );

        // Model: waiting codes in q; each popped code expands into a per-cycle output schedule
        initial begin : model
            int         q[$];
            logic [7:0] sched[$];
            logic [7:0] exp_d;
            logic       exp_busy;
            logic       act;
            logic       push;
            int         cv;
            exp_d    = 8'd0;
            exp_busy = 1'b0;
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    q.delete();
                    sched.delete();
                    exp_d    = 8'd0;
                    exp_busy = 1'b0;
                end else begin
                    push = in_valid && (q.size() < D);
                    cv   = int'(code_s);
                    act  = 1'b0;
                    if (sched.size() == 0 && q.size() > 0) begin
                        int hc;
                        hc = q.pop_front();
                        for (int i = 0; i < H; i++) sched.push_back(8'(1 << hc));
                        for (int i = 0; i < G; i++) sched.push_back(8'd0);
                    end
                    if (sched.size() > 0) begin
                        exp_d = sched.pop_front();
                        act   = 1'b1;
                    end else begin
                        exp_d = 8'd0;
                    end
                    if (push) q.push_back(cv);
                    exp_busy = act || (q.size() > 0);
                end
                @(negedge clk);
                check($sformatf("inst%0d_d", g), d_w[g], exp_d);
                check($sformatf("inst%0d_out_valid", g), ov_w[g], |exp_d);
                check($sformatf("inst%0d_busy", g), busy_w[g], exp_busy);
                check($sformatf("inst%0d_in_ready", g), rdy_w[g], rst_n && (q.size() < D));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (busy_w != 3'b000 && n < 200) begin
            cyc();
            n++;
        end
        check({nm, "_drain"}, (busy_w == 3'b000), 1'b1);
    endtask

    initial begin : stim
        int   bp[6];
        int   rec[$];
        int   idx;
        int   n;
        logic acc;
        logic saw_full;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        code_s   = 3'd7;

        // Reset held with in_valid high: nothing accepted, all outputs low
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            check("rst_in_ready", rdy_w, 3'b000);
            check("rst_d", d_w[0], 8'd0);
            check("rst_out_valid", ov_w, 3'b000);
            check("rst_busy", busy_w, 3'b000);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        check("post_rst_busy", busy_w[0], 1'b0);
        check("post_rst_ready", rdy_w[0], 1'b1);

        // Single code 5 on inst0: not bypassed, d5 for 4 cycles, one gap cycle, then idle
        in_valid = 1'b1;
        code_s   = 3'd5;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("single_k_d", d_w[0], 8'd0);
        check("single_k_busy", busy_w[0], 1'b1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            @(negedge clk);
            check($sformatf("single_k%0d_d", i), d_w[0], 8'h20);
            check($sformatf("single_k%0d_ov", i), ov_w[0], 1'b1);
        end
        cyc();
        @(negedge clk);
        check("single_gap_d", d_w[0], 8'd0);
        check("single_gap_ov", ov_w[0], 1'b0);
        cyc();
        @(negedge clk);
        check("single_idle_busy", busy_w[0], 1'b0);
        drain("single");

        // Full sweep 0..7 with in_valid held; inst0 must fill and back-pressure
        idx      = 0;
        n        = 0;
        saw_full = 1'b0;
        while (idx < 8 && n < 200) begin
            in_valid = 1'b1;
            code_s   = 3'(idx);
            acc      = rdy_w[0];
            if (!acc) saw_full = 1'b1;
            cyc();
            if (acc) idx++;
            n++;
        end
        check("sweep_all_sent", idx, 8);
        check("sweep_full_seen", saw_full, 1'b1);
        drain("sweep");

        // Contiguous repeat of code 3 on inst1 (GAP=0): one 8-cycle pulse
        in_valid = 1'b1;
        code_s   = 3'd3;
        cyc();
        @(negedge clk);
        check("repeat_k_d", d_w[1], 8'd0);
        cyc();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) cyc();
            @(negedge clk);
            check($sformatf("repeat_c%0d_d", i), d_w[1], 8'h08);
            check($sformatf("repeat_c%0d_ov", i), ov_w[1], 1'b1);
        end
        cyc();
        @(negedge clk);
        check("repeat_end_d", d_w[1], 8'd0);
        drain("repeat");

        // Backpressure stream on inst2: output order equals input order, nothing lost
        bp  = '{1, 6, 2, 7, 0, 5};
        idx = 0;
        n   = 0;
        rec.delete();
        while (rec.size() < 6 && n < 100) begin
            if (idx < 6) begin
                in_valid = 1'b1;
                code_s   = 3'(bp[idx]);
                acc      = rdy_w[2];
            end else begin
                in_valid = 1'b0;
                acc      = 1'b0;
            end
            cyc();
            if (acc) idx++;
            @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                if (ov_w[2] && d_w[2][j]) rec.push_back(j);
            end
            n++;
        end
        in_valid = 1'b0;
        check("bp_count", rec.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_order%0d", i), (i < rec.size()) ? rec[i] : 32'hFFFF, bp[i]);
        end
        drain("bp");

        // Reset in the second DRIVE cycle of inst0 with codes 2 and 4 queued
        in_valid = 1'b1;
        code_s   = 3'd1;
        cyc();
        code_s   = 3'd2;
        cyc();
        code_s   = 3'd4;
        cyc();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("midrst_pre_d", d_w[0], 8'h02);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_d", d_w[0], 8'd0);
        check("midrst_ov", ov_w[0], 1'b0);
        check("midrst_busy", busy_w[0], 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            @(negedge clk);
            check($sformatf("midrst_flushed%0d", i), d_w[0], 8'd0);
        end

        // Random traffic at increasing load with occasional resets
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 500; i++) begin
                rst_n    = ($urandom_range(0, 149) != 0);
                in_valid = ($urandom_range(0, 99) < 25 * (blk + 1));
                code_s   = 3'($urandom_range(0, 7));
                cyc();
            end
        end
        rst_n = 1'b1;
        drain("random");

        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
